// File: rtl/m_store_unit_pkg.sv
// Shared types and helpers for the M-stage store path: store-op codes,
// buffer entry layout and sb/sh/sw lane packing.
package m_store_unit_pkg;

  localparam int unsigned ST_ADDR_W = 32;
  localparam int unsigned ST_DATA_W = 32;
  localparam int unsigned ST_BE_W   = 4;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } st_op_e;

  typedef struct packed {
    logic [ST_BE_W-1:0]   be;
    logic [ST_DATA_W-1:0] data;
  } st_pack_t;

  // One store-buffer entry; addr is word aligned (bits [1:0] are zero).
  typedef struct packed {
    logic [ST_ADDR_W-1:0] addr;
    logic [ST_BE_W-1:0]   be;
    logic [ST_DATA_W-1:0] data;
  } st_entry_t;

  // Replicate the narrow value across lanes and select the lanes by offset.
  function automatic st_pack_t pack_store(input st_op_e               op,
                                          input logic [1:0]           off,
                                          input logic [ST_DATA_W-1:0] wdata);
    st_pack_t p;
    p.be   = '0;
    p.data = '0;
    case (op)
      ST_SB: begin
        p.be   = ST_BE_W'(4'b0001 << off);
        p.data = {4{wdata[7:0]}};
      end
      ST_SH: begin
        p.be   = off[1] ? 4'b1100 : 4'b0011;
        p.data = {2{wdata[15:0]}};
      end
      ST_SW: begin
        p.be   = 4'b1111;
        p.data = wdata;
      end
      default: begin
        p.be   = '0;
        p.data = '0;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/m_store_unit_if.sv
// Pipeline-side and data-memory-side signals of the M-stage store unit.
interface m_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              valid_M;
  logic [1:0]        store_op_M;
  logic [ADDR_W-1:0] addr_M;
  logic [31:0]       wdata_M;
  logic              stall_M;
  logic              exc_ades_M;
  logic              busy_M;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  // Store unit view.
  modport slave (
    input  valid_M, store_op_M, addr_M, wdata_M, mem_ack,
    output stall_M, exc_ades_M, busy_M, mem_req, mem_addr, mem_be, mem_wdata
  );

  // Pipeline/memory (environment) view.
  modport master (
    output valid_M, store_op_M, addr_M, wdata_M, mem_ack,
    input  stall_M, exc_ades_M, busy_M, mem_req, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/m_store_unit_store_fifo.sv
// DEPTH-entry store buffer with a registered head entry, so the memory-side
// payload comes straight from flops and the next entry follows an ack with no bubble.
module store_fifo
  import m_store_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  st_entry_t        din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output st_entry_t        head_o
);

  st_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  st_entry_t        head_q, head_d;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == (DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = head_q;

  // Push into a full buffer is only allowed when the head leaves the same cycle.
  assign pop  = pop_i & ~empty_o;
  assign push = push_i & (~full_o | pop);

  // Pointer/count update and look-ahead of the entry that will be at the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push && ((count_q - CNT_W'(pop)) == '0)) begin
      head_d = din_i;
    end else if (pop && (count_q > CNT_W'(1))) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/m_store_unit.sv
// M-stage store path: packs sb/sh/sw into lane-aligned words, buffers them and
// drains to data memory over req/ack. Optional misaligned-store exception: STORE_ALIGN_EXC_EN.
module m_store_unit
  import m_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  m_store_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  st_op_e           op;
  st_pack_t         pack;
  st_entry_t        entry;
  st_entry_t        head;
  logic             is_store;
  logic             misaligned;
  logic             st;
  logic             deq;
  logic             enq;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;

  assign op       = st_op_e'(bus.store_op_M);
  assign is_store = bus.valid_M & (op != ST_NONE);
  assign pack     = pack_store(op, bus.addr_M[1:0], bus.wdata_M);

`ifdef STORE_ALIGN_EXC_EN
  // Misaligned sh/sw raise AdES and are dropped instead of being buffered.
  assign misaligned     = ((op == ST_SH) & bus.addr_M[0]) |
                          ((op == ST_SW) & (bus.addr_M[1:0] != 2'b00));
  assign bus.exc_ades_M = reset & bus.valid_M & misaligned;
`else
  assign misaligned     = 1'b0;
  assign bus.exc_ades_M = 1'b0;
`endif

  assign st  = is_store & ~misaligned;
  assign deq = ~empty & bus.mem_ack;
  assign enq = st & (~full | deq);

  assign entry.addr = ST_ADDR_W'({bus.addr_M[ADDR_W-1:2], 2'b00});
  assign entry.be   = pack.be;
  assign entry.data = pack.data;

  // A full buffer only stalls when the head is not leaving this cycle.
  assign bus.stall_M = st & full & ~bus.mem_ack;

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (enq),
    .pop_i   (deq),
    .din_i   (entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  assign bus.busy_M    = (count != '0);
  assign bus.mem_req   = ~empty;
  assign bus.mem_addr  = ADDR_W'(head.addr);
  assign bus.mem_be    = head.be;
  assign bus.mem_wdata = head.data;

endmodule
